// File: rtl/finalizer_mixer.sv
// Finalizer sound-path mixer: sums NCH gain-scaled signed sources into one
// saturated 16-bit sample every DIV clocks, time-sharing a single multiplier.
module finalizer_mixer #(
  parameter int NCH = 4,
  parameter int DIV = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [16*NCH-1:0]    ch_in,
  input  logic [8*NCH-1:0]     gain,
  input  logic                 mute,
  output logic signed [15:0]   out,
  output logic                 out_stb,
  output logic                 clip
);

  localparam int DW = $clog2(DIV);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  // The MAC sequence must finish before the next tick, otherwise samples would
  // be silently dropped, so refuse to build an unworkable configuration.
  if (DIV < NCH + 3) begin : g_div_check
    $fatal(1, "finalizer_mixer: DIV (%0d) must be at least NCH+3 (%0d)", DIV, NCH + 3);
  end
  if (NCH < 1 || NCH > 8) begin : g_nch_check
    $fatal(1, "finalizer_mixer: NCH (%0d) must be in 1..8", NCH);
  end

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DW-1:0]       divider;
  logic                tick;
  logic [IW-1:0]       idx;
  logic                last_mac;
  logic signed [15:0]  ch_snap   [NCH];
  logic [7:0]          gain_snap [NCH];
  logic                mute_snap;
  logic signed [27:0]  acc;
  logic signed [24:0]  ch_ext;
  logic signed [24:0]  gain_ext;
  logic signed [24:0]  prod;
  logic signed [20:0]  s;

  // Free-running sample-rate divider; tick marks the last clock of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider <= '0;
    end else if (divider == DW'(DIV - 1)) begin
      divider <= '0;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  assign tick     = (divider == DW'(DIV - 1));
  assign last_mac = (idx == IW'(NCH - 1));

  // Shared multiplier: gains are unsigned Q1.7, so they are zero-extended
  // before the signed multiply. The full product always fits in 25 bits.
  assign ch_ext   = {{9{ch_snap[idx][15]}}, ch_snap[idx]};
  assign gain_ext = {17'd0, gain_snap[idx]};
  assign prod     = ch_ext * gain_ext;

  // Dropping the low 7 accumulator bits is an arithmetic shift right by 7,
  // which rounds toward minus infinity.
  assign s = acc[27:7];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one MAC cycle per channel, then one saturation cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = MAC;
      MAC:     if (last_mac) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: snapshot inputs on tick, accumulate products, then saturate
  // and publish the sample with a single-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        ch_snap[i]   <= '0;
        gain_snap[i] <= '0;
      end
      mute_snap <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_stb   <= 1'b0;
      clip      <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < NCH; i++) begin
              ch_snap[i]   <= ch_in[16*i +: 16];
              gain_snap[i] <= gain[8*i +: 8];
            end
            mute_snap <= mute;
            acc       <= '0;
            idx       <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{3{prod[24]}}, prod};
          idx <= idx + 1'b1;
        end
        SAT: begin
          out_stb <= 1'b1;
          if (mute_snap) begin
            out  <= '0;
            clip <= 1'b0;
          end else if (s > 21'sd32767) begin
            out  <= 16'sh7FFF;
            clip <= 1'b1;
          end else if (s < -21'sd32768) begin
            out  <= 16'sh8000;
            clip <= 1'b1;
          end else begin
            out  <= s[15:0];
            clip <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_finalizer_mixer.sv
// Directed bench for finalizer_mixer: hand-computed samples, strobe timing,
// saturation boundaries, input snapshotting, mid-sample reset and mute.
module tb_finalizer_mixer;

  localparam int NCH = 4;
  localparam int DIV = 16;

  logic                clk;
  logic                reset;
  logic [16*NCH-1:0]   ch_in;
  logic [8*NCH-1:0]    gain;
  logic                mute;
  logic signed [15:0]  out;
  logic                out_stb;
  logic                clip;

  int compared   = 0;
  int mismatched = 0;
  int n;

  finalizer_mixer #(.NCH(NCH), .DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .ch_in   (ch_in),
    .gain    (gain),
    .mute    (mute),
    .out     (out),
    .out_stb (out_stb),
    .clip    (clip)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one full input vector (channels, gains, mute).
  task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3,
                               input int g0, input int g1, input int g2, input int g3,
                               input logic m);
    ch_in = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    gain  = {8'(g3), 8'(g2), 8'(g1), 8'(g0)};
    mute  = m;
  endtask

  // Called at a negedge; returns at the negedge where out_stb is high,
  // reporting how many rising edges that took. Bounded wait.
  task automatic waitStrobe(output int cycles);
    int   k   = 0;
    logic got = 1'b0;
    while (!got && k < 4 * DIV) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_stb) got = 1'b1;
    end
    cycles = k;
    checkOutput("strobeSeen", 32'(got), 1);
  endtask

  // Apply a vector right after a strobe; it is captured at the next tick and
  // its result must appear exactly one period after the previous strobe.
  task automatic runSample(input string tag,
                           input int c0, input int c1, input int c2, input int c3,
                           input int g0, input int g1, input int g2, input int g3,
                           input logic m, input int expOut, input int expClip);
    int k;
    applyStimulus(c0, c1, c2, c3, g0, g1, g2, g3, m);
    waitStrobe(k);
    checkOutput({tag, "Period"}, k, DIV);
    checkOutput({tag, "Out"}, out, expOut);
    checkOutput({tag, "Clip"}, 32'(clip), expClip);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1000, 0, 0, 0, 128, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("resetOut", out, 0);
    checkOutput("resetStb", 32'(out_stb), 0);
    checkOutput("resetClip", 32'(clip), 0);

    // First tick is captured on the DIV-th edge after release; the result
    // strobes NCH+1 edges later.
    reset = 1'b0;
    waitStrobe(n);
    checkOutput("firstStrobeDelay", n, DIV + NCH + 1);
    checkOutput("unityOut", out, 1000);
    checkOutput("unityClip", 32'(clip), 0);

    // Strobe is a single-cycle pulse and out holds afterwards.
    @(negedge clk);
    checkOutput("stbWidth", 32'(out_stb), 0);
    checkOutput("outHold", out, 1000);
    waitStrobe(n);
    checkOutput("periodAfterPulse", n, DIV - 1);

    // -1*64 = -64, floor(-64/128) = -1 ; 1*64 = 64, floor(64/128) = 0
    runSample("roundNeg", -1, 0, 0, 0, 64, 0, 0, 0, 1'b0, -1, 0);
    runSample("roundPos",  1, 0, 0, 0, 64, 0, 0, 0, 1'b0,  0, 0);

    // 4*32767*255 >> 7 far exceeds 32767; 4*-32768*255 >> 7 far below -32768
    runSample("satPos", 32767, 32767, 32767, 32767, 255, 255, 255, 255, 1'b0, 32767, 1);
    runSample("satNeg", -32768, -32768, -32768, -32768, 255, 255, 255, 255, 1'b0, -32768, 1);

    // Exactly at the limits with unity gain: no clipping.
    runSample("edgeMax", 32767, 0, 0, 0, 128, 0, 0, 0, 1'b0, 32767, 0);
    runSample("edgeMin", -32768, 0, 0, 0, 128, 0, 0, 0, 1'b0, -32768, 0);
    // One LSB over: (32767+1)*128 >> 7 = 32768 -> clipped.
    runSample("edgeOver", 32767, 1, 0, 0, 128, 128, 0, 0, 1'b0, 32767, 1);

    // 12800 + 12800 - 38400 + 102000 = 89200; floor(89200/128) = 696
    runSample("mix", 100, 200, -300, 400, 128, 64, 128, 255, 1'b0, 696, 0);

    // Mute forces zero even with a live channel.
    runSample("mute", 1000, 0, 0, 0, 128, 0, 0, 0, 1'b1, 0, 0);

    // Snapshot: ch0 changes one cycle after the capture edge.
    applyStimulus(1000, 0, 0, 0, 128, 0, 0, 0, 1'b0);
    repeat (DIV - NCH - 1) @(posedge clk);
    @(negedge clk);
    applyStimulus(5000, 0, 0, 0, 128, 0, 0, 0, 1'b0);
    waitStrobe(n);
    checkOutput("tickToStrobe", n, NCH + 1);
    checkOutput("snapOld", out, 1000);
    waitStrobe(n);
    checkOutput("snapPeriod", n, DIV);
    checkOutput("snapNew", out, 5000);

    // Reset two edges after the capture edge, held for three cycles.
    repeat (DIV - NCH - 1 + 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(-1234, 0, 0, 0, 128, 0, 0, 0, 1'b0);
    #1;
    checkOutput("midResetOut", out, 0);
    checkOutput("midResetClip", 32'(clip), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    waitStrobe(n);
    checkOutput("postResetDelay", n, DIV + NCH + 1);
    checkOutput("postResetOut", out, -1234);
    checkOutput("postResetClip", 32'(clip), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
